// File: rtl/tmds_encoder.sv
// tmds_encoder: DVI 1.0 TMDS encoder for three channels. Channel 0 is blue,
// channel 1 is green and channel 2 is red.
// The data path is a 3-stage pipeline: input register, q_m formation, then
// DC balance feeding the output register. During blanking the encoder emits
// control codes, and channel 0 carries {vsync, hsync}.
// Optional macro HDMI_GUARD_BAND_EN adds a 10-cycle look-ahead delay line.
// With it, the encoder emits the HDMI preamble and video guard band ahead of
// each active-video run, and total latency becomes 13.
module tmds_encoder #(
  parameter int PIPE_LAT = 3
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        video_vsync,
  input  logic        video_hsync,
  input  logic        video_den,
  input  logic [23:0] video_pixel,
  output logic [9:0]  tmds_ch0,
  output logic [9:0]  tmds_ch1,
  output logic [9:0]  tmds_ch2
);

  // Stages that carry den/sync alongside the data before the output register.
  localparam int STAGES = PIPE_LAT - 1;

  localparam logic [9:0] CTL_00  = 10'b1101010100;
  localparam logic [9:0] CTL_01  = 10'b0010101011;
  localparam logic [9:0] CTL_10  = 10'b0101010100;
  localparam logic [9:0] CTL_11  = 10'b1010101011;
  localparam logic [9:0] GB_CH02 = 10'b1011001100;
  localparam logic [9:0] GB_CH1  = 10'b0100110011;

  typedef enum logic [1:0] {
    CTL_SYNC,
    CTL_PREAMBLE,
    CTL_GUARD
  } ctl_kind_t;

  function automatic logic [3:0] ones8(input logic [7:0] b);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n += {3'b000, b[i]};
    return n;
  endfunction

  // Transition-minimising stage: chooses XOR or XNOR chaining from N1(D).
  function automatic logic [8:0] min_trans(input logic [7:0] d, input logic [3:0] n1);
    logic [8:0] q;
    logic       use_xnor;
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] ctl_code(input logic [1:0] c);
    unique case (c)
      2'b00:   return CTL_00;
      2'b01:   return CTL_01;
      2'b10:   return CTL_10;
      default: return CTL_11;
    endcase
  endfunction

  // Sample presented to S1: either the live inputs or the delay-line tail.
  logic        s0_den;
  logic        s0_vsync;
  logic        s0_hsync;
  logic [23:0] s0_pixel;
  ctl_kind_t   s0_kind;

`ifdef HDMI_GUARD_BAND_EN
  localparam int LOOKAHEAD = 10;

  typedef struct packed {
    logic        den;
    logic        vsync;
    logic        hsync;
    logic [23:0] pixel;
  } sample_t;

  sample_t              dly [LOOKAHEAD];
  logic [LOOKAHEAD:1]   den_ahead;

  // Look-ahead delay line; its tail feeds S1 while the rest reveals upcoming den.
  always_ff @(posedge pixel_clock) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values
    // regardless of statement order.
    if (!reset) begin
      // NOTE: this small array is flushed on reset because stale den bits would
      // otherwise fake a guard band after reset.
      for (int i = 0; i < LOOKAHEAD; i++) dly[i] <= '0;
    end else begin
      dly[0] <= {video_den, video_vsync, video_hsync, video_pixel};
      for (int i = 1; i < LOOKAHEAD; i++) dly[i] <= dly[i-1];
    end
  end

  // Classify blanking samples by their distance to the next den rise.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch can form.
    den_ahead = '0;
    s0_kind   = CTL_SYNC;
    s0_den    = dly[LOOKAHEAD-1].den;
    s0_vsync  = dly[LOOKAHEAD-1].vsync;
    s0_hsync  = dly[LOOKAHEAD-1].hsync;
    s0_pixel  = dly[LOOKAHEAD-1].pixel;
    for (int k = 1; k < LOOKAHEAD; k++) den_ahead[k] = dly[LOOKAHEAD-1-k].den;
    den_ahead[LOOKAHEAD] = video_den;
    // Scan from far to near so the nearest active sample decides.
    for (int k = LOOKAHEAD; k >= 1; k--) begin
      if (den_ahead[k]) s0_kind = (k <= 2) ? CTL_GUARD : CTL_PREAMBLE;
    end
  end
`else
  // Plain DVI: inputs feed S1 directly and blanking is always sync codes.
  always_comb begin
    s0_den   = video_den;
    s0_vsync = video_vsync;
    s0_hsync = video_hsync;
    s0_pixel = video_pixel;
    s0_kind  = CTL_SYNC;
  end
`endif

  logic [STAGES-1:0] den_pipe;
  logic [STAGES-1:0] vsync_pipe;
  logic [STAGES-1:0] hsync_pipe;
  ctl_kind_t         kind_pipe [STAGES];

  logic [7:0] s1_data [3];
  logic [3:0] s1_n1   [3];
  logic [8:0] qm_nxt  [3];
  logic [8:0] s2_qm   [3];
  logic [3:0] s2_n1   [3];
  logic [3:0] s2_n0   [3];

  logic signed [4:0] cnt      [3];
  logic signed [4:0] cnt_nxt  [3];
  logic signed [4:0] disp     [3];
  logic signed [4:0] bias_set [3];
  logic signed [4:0] bias_clr [3];
  logic [9:0]        sym      [3];
  logic [9:0]        sym_nxt  [3];

  logic      den_s3;
  logic      vsync_s3;
  logic      hsync_s3;
  ctl_kind_t kind_s3;

  // Carry den, syncs and blanking kind alongside the data stages.
  always_ff @(posedge pixel_clock) begin
    if (!reset) begin
      den_pipe   <= '0;
      vsync_pipe <= '0;
      hsync_pipe <= '0;
      for (int i = 0; i < STAGES; i++) kind_pipe[i] <= CTL_SYNC;
    end else begin
      den_pipe[0]   <= s0_den;
      vsync_pipe[0] <= s0_vsync;
      hsync_pipe[0] <= s0_hsync;
      kind_pipe[0]  <= s0_kind;
      for (int i = 1; i < STAGES; i++) begin
        den_pipe[i]   <= den_pipe[i-1];
        vsync_pipe[i] <= vsync_pipe[i-1];
        hsync_pipe[i] <= hsync_pipe[i-1];
        kind_pipe[i]  <= kind_pipe[i-1];
      end
    end
  end

  // S1: register each channel byte and its popcount.
  always_ff @(posedge pixel_clock) begin
    if (!reset) begin
      for (int c = 0; c < 3; c++) begin
        s1_data[c] <= '0;
        s1_n1[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        s1_data[c] <= s0_pixel[8*c +: 8];
        s1_n1[c]   <= ones8(s0_pixel[8*c +: 8]);
      end
    end
  end

  // S2 combinational: q_m from the registered byte.
  always_comb begin
    for (int c = 0; c < 3; c++) qm_nxt[c] = min_trans(s1_data[c], s1_n1[c]);
  end

  // S2: register q_m together with the ones/zeros count of its low byte.
  always_ff @(posedge pixel_clock) begin
    if (!reset) begin
      for (int c = 0; c < 3; c++) begin
        s2_qm[c] <= '0;
        s2_n1[c] <= '0;
        s2_n0[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        s2_qm[c] <= qm_nxt[c];
        s2_n1[c] <= ones8(qm_nxt[c][7:0]);
        s2_n0[c] <= 4'd8 - ones8(qm_nxt[c][7:0]);
      end
    end
  end

  assign den_s3   = den_pipe[STAGES-1];
  assign vsync_s3 = vsync_pipe[STAGES-1];
  assign hsync_s3 = hsync_pipe[STAGES-1];
  assign kind_s3  = kind_pipe[STAGES-1];

  // S3 combinational: DC balance in active video, control symbols in blanking.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      disp[c]     = $signed({1'b0, s2_n1[c]}) - $signed({1'b0, s2_n0[c]});
      bias_set[c] = $signed({3'b000, s2_qm[c][8], 1'b0});
      bias_clr[c] = $signed({3'b000, ~s2_qm[c][8], 1'b0});
      if ((cnt[c] == 5'sd0) || (disp[c] == 5'sd0)) begin
        sym_nxt[c] = {~s2_qm[c][8], s2_qm[c][8],
                      s2_qm[c][8] ? s2_qm[c][7:0] : ~s2_qm[c][7:0]};
        cnt_nxt[c] = s2_qm[c][8] ? (cnt[c] + disp[c]) : (cnt[c] - disp[c]);
      end else if (((cnt[c] > 5'sd0) && (disp[c] > 5'sd0)) ||
                   ((cnt[c] < 5'sd0) && (disp[c] < 5'sd0))) begin
        sym_nxt[c] = {1'b1, s2_qm[c][8], ~s2_qm[c][7:0]};
        cnt_nxt[c] = cnt[c] + bias_set[c] - disp[c];
      end else begin
        sym_nxt[c] = {1'b0, s2_qm[c][8], s2_qm[c][7:0]};
        cnt_nxt[c] = cnt[c] - bias_clr[c] + disp[c];
      end
    end

    if (!den_s3) begin
      for (int c = 0; c < 3; c++) cnt_nxt[c] = '0;
      sym_nxt[0] = (kind_s3 == CTL_GUARD) ? GB_CH02 : ctl_code({vsync_s3, hsync_s3});
      unique case (kind_s3)
        CTL_GUARD:    sym_nxt[1] = GB_CH1;
        CTL_PREAMBLE: sym_nxt[1] = CTL_01;
        default:      sym_nxt[1] = CTL_00;
      endcase
      sym_nxt[2] = (kind_s3 == CTL_GUARD) ? GB_CH02 : CTL_00;
    end
  end

  // S3: output symbols and running disparity.
  always_ff @(posedge pixel_clock) begin
    if (!reset) begin
      for (int c = 0; c < 3; c++) begin
        sym[c] <= CTL_00;
        cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        sym[c] <= sym_nxt[c];
        cnt[c] <= cnt_nxt[c];
      end
    end
  end

  assign tmds_ch0 = sym[0];
  assign tmds_ch1 = sym[1];
  assign tmds_ch2 = sym[2];

endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder: scoreboard bench for tmds_encoder in its default DVI build.
module tb_tmds_encoder;

  localparam int LAT = 3;
  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;

  logic        pixel_clock = 1'b0;
  logic        reset       = 1'b0;
  logic        video_vsync = 1'b0;
  logic        video_hsync = 1'b0;
  logic        video_den   = 1'b0;
  logic [23:0] video_pixel = '0;
  logic [9:0]  tmds_ch0;
  logic [9:0]  tmds_ch1;
  logic [9:0]  tmds_ch2;

  tmds_encoder #(.PIPE_LAT(LAT)) dut (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .video_vsync (video_vsync),
    .video_hsync (video_hsync),
    .video_den   (video_den),
    .video_pixel (video_pixel),
    .tmds_ch0    (tmds_ch0),
    .tmds_ch1    (tmds_ch1),
    .tmds_ch2    (tmds_ch2)
  );

  always #5 pixel_clock = ~pixel_clock;

  typedef struct packed {
    logic            den;
    logic [2:0][7:0] byt;
    logic [2:0][9:0] sym;
    logic [2:0][4:0] cnt;
  } exp_t;

  typedef struct {
    logic        den;
    logic        vs;
    logic        hs;
    logic [23:0] pix;
    logic [9:0]  s0;
    logic [9:0]  s1;
    logic [9:0]  s2;
    int          cnt;
  } vec_t;

  exp_t sb[$];
  int   model_cnt [3];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  function automatic logic [9:0] ctl_sym(input logic [1:0] c);
    case (c)
      2'b00:   return C00;
      2'b01:   return C01;
      2'b10:   return C10;
      default: return C11;
    endcase
  endfunction

  // Reference DVI 1.0 encoder for one byte; cnt is the running disparity.
  function automatic logic [9:0] enc_byte(input logic [7:0] d, inout int cnt);
    int         ones_d, n1, n0;
    bit         use_xnor;
    logic [8:0] q;
    logic [9:0] s;
    ones_d   = $countones(d);
    use_xnor = (ones_d > 4) || (ones_d == 4 && !d[0]);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !use_xnor;
    n1 = $countones(q[7:0]);
    n0 = 8 - n1;
    if (cnt == 0 || n1 == n0) begin
      s   = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      cnt = q[8] ? cnt + n1 - n0 : cnt + n0 - n1;
    end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
      s   = {1'b1, q[8], ~q[7:0]};
      cnt = cnt + 2 * int'(q[8]) + n0 - n1;
    end else begin
      s   = {1'b0, q[8], q[7:0]};
      cnt = cnt - 2 * int'(!q[8]) + n1 - n0;
    end
    return s;
  endfunction

  // Receiver-side DVI decode, used to recover the byte from a DUT symbol.
  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d, b;
    d    = s[9] ? ~s[7:0] : s[7:0];
    b[0] = d[0];
    for (int i = 1; i < 8; i++) b[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return b;
  endfunction

  task automatic build_exp(input logic den, input logic vs, input logic hs,
                           input logic [23:0] pix, output exp_t e);
    int t;
    e.den = den;
    for (int c = 0; c < 3; c++) e.byt[c] = pix[8*c +: 8];
    if (den) begin
      for (int c = 0; c < 3; c++) begin
        t = model_cnt[c];
        e.sym[c] = enc_byte(e.byt[c], t);
        model_cnt[c] = t;
      end
    end else begin
      for (int c = 0; c < 3; c++) model_cnt[c] = 0;
      e.sym[0] = ctl_sym({vs, hs});
      e.sym[1] = C00;
      e.sym[2] = C00;
    end
    for (int c = 0; c < 3; c++) e.cnt[c] = 5'(model_cnt[c]);
  endtask

  task automatic compare_out();
    exp_t       e;
    logic [9:0] got [3];
    logic       out_of_range;
    got[0] = tmds_ch0;
    got[1] = tmds_ch1;
    got[2] = tmds_ch2;
    e = sb.pop_front();
    for (int c = 0; c < 3; c++) begin
      check($sformatf("sym ch%0d cyc%0d", c, cyc), {22'b0, got[c]}, {22'b0, e.sym[c]});
      check($sformatf("cnt ch%0d cyc%0d", c, cyc), {27'b0, dut.cnt[c]}, {27'b0, e.cnt[c]});
      out_of_range = (dut.cnt[c] > 5'sd10) || (dut.cnt[c] < -5'sd10);
      check($sformatf("cnt_bound ch%0d cyc%0d", c, cyc), {31'b0, out_of_range}, 32'd0);
      if (e.den) begin
        check($sformatf("decode ch%0d cyc%0d", c, cyc), {24'b0, decode(got[c])}, {24'b0, e.byt[c]});
      end
    end
  endtask

  task automatic drive_step(input logic den, input logic vs, input logic hs,
                            input logic [23:0] pix, input exp_t e);
    video_den   = den;
    video_vsync = vs;
    video_hsync = hs;
    video_pixel = pix;
    sb.push_back(e);
    @(posedge pixel_clock);
    #1;
    cyc++;
    compare_out();
  endtask

  task automatic step(input logic den, input logic vs, input logic hs, input logic [23:0] pix);
    exp_t e;
    build_exp(den, vs, hs, pix, e);
    drive_step(den, vs, hs, pix, e);
  endtask

  // Holds reset for the given cycles, checks the reset state, then refills the
  // scoreboard with the two flushed (control 00) stages still in the pipe.
  task automatic apply_reset(input int cycles);
    exp_t e;
    reset = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge pixel_clock);
      #1;
      cyc++;
      check("rst ch0", {22'b0, tmds_ch0}, {22'b0, C00});
      check("rst ch1", {22'b0, tmds_ch1}, {22'b0, C00});
      check("rst ch2", {22'b0, tmds_ch2}, {22'b0, C00});
      for (int c = 0; c < 3; c++) check($sformatf("rst cnt ch%0d", c), {27'b0, dut.cnt[c]}, 32'd0);
    end
    reset = 1'b1;
    sb.delete();
    for (int c = 0; c < 3; c++) model_cnt[c] = 0;
    build_exp(1'b0, 1'b0, 1'b0, 24'h0, e);
    sb.push_back(e);
    sb.push_back(e);
  endtask

  initial begin
    vec_t        tab [9];
    exp_t        e;
    logic [23:0] rpix;
    int          dl, bl;

    tab[0] = '{1'b0, 1'b0, 1'b0, 24'h0,      C00, C00, C00, 0};
    tab[1] = '{1'b0, 1'b0, 1'b1, 24'h0,      C01, C00, C00, 0};
    tab[2] = '{1'b0, 1'b1, 1'b1, 24'h0,      C11, C00, C00, 0};
    tab[3] = '{1'b0, 1'b1, 1'b0, 24'h0,      C10, C00, C00, 0};
    tab[4] = '{1'b0, 1'b0, 1'b0, 24'h123456, C00, C00, C00, 0};
    tab[5] = '{1'b1, 1'b0, 1'b0, 24'h0, 10'h100, 10'h100, 10'h100, -8};
    tab[6] = '{1'b1, 1'b0, 1'b0, 24'h0, 10'h3FF, 10'h3FF, 10'h3FF, 2};
    tab[7] = '{1'b1, 1'b0, 1'b0, 24'h0, 10'h100, 10'h100, 10'h100, -6};
    tab[8] = '{1'b0, 1'b1, 1'b0, 24'h0,      C10, C00, C00, 0};

    apply_reset(5);

    // Control codes and the all-zero pixel disparity walk.
    for (int i = 0; i < 9; i++) begin
      build_exp(tab[i].den, tab[i].vs, tab[i].hs, tab[i].pix, e);
      e.sym[0] = tab[i].s0;
      e.sym[1] = tab[i].s1;
      e.sym[2] = tab[i].s2;
      for (int c = 0; c < 3; c++) e.cnt[c] = 5'(tab[i].cnt);
      drive_step(tab[i].den, tab[i].vs, tab[i].hs, tab[i].pix, e);
    end

    // Long saturated run: all ones must stay balanced and decodable.
    step(1'b0, 1'b0, 1'b0, 24'h0);
    repeat (64) step(1'b1, 1'b0, 1'b0, 24'hFFFFFF);

    // Single-cycle den pulses alternating with single control cycles.
    for (int i = 0; i < 12; i++) begin
      rpix = 24'($urandom);
      step(1'b1, 1'b0, 1'b0, rpix);
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'h0);
    end

    // Random active runs and blanking runs.
    for (int run = 0; run < 60; run++) begin
      dl = $urandom_range(1, 8);
      bl = $urandom_range(1, 5);
      for (int i = 0; i < dl; i++) begin
        rpix = 24'($urandom);
        step(1'b1, 1'b0, 1'b0, rpix);
      end
      for (int i = 0; i < bl; i++) begin
        rpix = 24'($urandom);
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rpix);
      end
    end

    // Reset mid-line discards in-flight pixels and zeroes disparity.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 24'h0F0F0F + 24'(i));
    video_den   = 1'b1;
    video_pixel = 24'hA5A5A5;
    apply_reset(1);
    for (int i = 0; i < 6; i++) begin
      rpix = 24'($urandom);
      step(1'b1, 1'b1, 1'b0, rpix);
    end

    // Drain the pipe with blanking.
    repeat (LAT) step(1'b0, 1'b0, 1'b1, 24'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
